fft_frame_rx: RTL and testbench
===============================

// Module: fft_frame_rx
// PURPOSE
//   Receiver end of the push/stall sample stream. It sits downstream of the FFT core output
//   and collects one N-point complex frame into a local buffer. It then replays the frame as
//   a push/stall stream toward the next consumer, optionally reordered from bit-reversed to
//   natural index order. Single buffer: a frame fills completely, then drains completely.
// PARAMETERS
//   N_POINTS  16  frame length in complex samples
//   LOG2N     4   log2(N_POINTS); index/counter width
//   DW        16  width of each real/imag component (two's complement, passed unmodified)
// PORTS
//   clk           in   1     rising-edge clock
//   reset         in   1     asynchronous, active-low reset
//   in_push       in   1     upstream sample valid
//   in_real       in   DW    upstream real part
//   in_imag       in   DW    upstream imag part
//   in_stall_F    out  1     registered; 1 = block is not accepting samples
//   out_push_F    out  1     registered; 1 = out_real_F/out_imag_F hold a valid sample
//   out_real_F    out  DW    registered real part
//   out_imag_F    out  DW    registered imag part
//   out_stall     in   1     downstream back-pressure
//   frame_done_F  out  1     one-cycle pulse after the last sample of a frame is emitted
//   ovf_F         out  1     sticky; a push arrived while in_stall_F=1
//   frame_cnt_F   out  8     count of frames fully emitted, wraps 255->0
// BEHAVIOUR
//   Reset (reset=0, async): state=FILL, wr_idx=rd_idx=0, in_stall_F=0, out_push_F=0,
//     out_real_F=out_imag_F=0, frame_done_F=0, ovf_F=0, frame_cnt_F=0. Buffer contents
//     are don't-care. Reset mid-frame discards the partial frame.
//   Accept rule: a sample is accepted on an edge where in_push=1 and in_stall_F=0.
//     A push with in_stall_F=1 is dropped: it does not change the buffer or the indices,
//     and it sets ovf_F=1. ovf_F clears only on reset.
//   FILL: each accept writes mem[waddr(wr_idx)] and increments wr_idx.
//     On the accept with wr_idx=N_POINTS-1: in_stall_F<=1, wr_idx<=0, state<=DRAIN.
//   DRAIN: on each edge with out_stall=0:
//     out_push_F<=1, {out_real_F,out_imag_F}<=mem[rd_idx], rd_idx++.
//     On each edge with out_stall=1: out_push_F<=0 and the data outputs hold.
//     The first out_push_F=1 appears one cycle after DRAIN is entered.
//     On the emit with rd_idx=N_POINTS-1: rd_idx<=0, state<=FILL, in_stall_F<=0,
//     frame_done_F<=1 (one cycle), frame_cnt_F++.
//   In FILL, out_push_F<=0 every cycle.
//   Latency: last accept at edge k; first emit at edge k+1; with out_stall held at 0,
//     the last emit is at edge k+N_POINTS and in_stall_F falls at that same edge.
//   Minimum frame period with no stalls: 2*N_POINTS cycles.
//   Pushes during DRAIN are always dropped and always flag ovf_F.
//   The buffer is written only in FILL and read only in DRAIN, so read and write never
//     collide.
// CONFIGURATION
//   BIT_REVERSE_EN defined:   waddr(i) = bit-reverse of i over LOG2N bits, so a bit-reversed
//                             input frame drains in natural order.
//   BIT_REVERSE_EN undefined: waddr(i) = i, straight pass-through order.
//   All other timing is identical in both builds.
// TESTING
//   1 Push 16 samples with real=i, imag=-i, out_stall=0 -> 16 consecutive out_push_F
//     pulses, real=0..15 (no macro), frame_done_F pulse, frame_cnt_F=1, ovf_F=0.
//   2 BIT_REVERSE_EN, same stimulus -> output positions 0..3 carry real=0,8,4,12;
//     the last output carries real=15.
//   3 Hold out_stall=1 for 5 cycles after DRAIN entry, then release -> no out_push_F
//     during the stall; the 16 samples then emit in order with none lost or duplicated.
//   4 Hold in_push=1 for 20 cycles -> exactly 16 samples accepted, ovf_F=1 from the 17th
//     push onward, emitted frame equals the first 16 samples.
//   5 Drive reset=0 after 7 accepts -> all outputs reach their reset values immediately;
//     the next 16 pushes form a clean frame.
//   6 Stream 256 frames -> frame_cnt_F wraps to 0 and frame_done_F pulses 256 times.

Source files
------------

// File: rtl/fft_frame_rx_if.sv
// Sample-stream bundle for fft_frame_rx: the upstream push/stall input side, the
// downstream push/stall output side, and the frame status flags.
interface fft_frame_rx_if #(
    parameter int DW = 16
);
    logic                 in_push;
    logic signed [DW-1:0] in_real;
    logic signed [DW-1:0] in_imag;
    logic                 in_stall_F;

    logic                 out_push_F;
    logic signed [DW-1:0] out_real_F;
    logic signed [DW-1:0] out_imag_F;
    logic                 out_stall;

    logic                 frame_done_F;
    logic                 ovf_F;
    logic [7:0]           frame_cnt_F;

    modport slave (
        input  in_push, in_real, in_imag, out_stall,
        output in_stall_F, out_push_F, out_real_F, out_imag_F,
               frame_done_F, ovf_F, frame_cnt_F
    );

    modport master (
        output in_push, in_real, in_imag, out_stall,
        input  in_stall_F, out_push_F, out_real_F, out_imag_F,
               frame_done_F, ovf_F, frame_cnt_F
    );
endinterface

// File: rtl/fft_frame_rx.sv
// Single-buffer frame collector: fills one N-point complex frame, then replays it downstream.
// Define BIT_REVERSE_EN to store bit-reversed input so the frame drains in natural order.
module fft_frame_rx #(
    parameter int N_POINTS = 16,
    parameter int LOG2N    = 4,
    parameter int DW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    fft_frame_rx_if.slave bus
);

    typedef enum logic {FILL, DRAIN} state_t;

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_POINTS - 1);

    state_t               state, state_d;
    logic [LOG2N-1:0]     wr_idx, rd_idx;
    logic [2*DW-1:0]      mem [N_POINTS];
    logic                 accept, emit, last_wr, last_rd;

    function automatic logic [LOG2N-1:0] waddr(input logic [LOG2N-1:0] i);
        logic [LOG2N-1:0] r;
`ifdef BIT_REVERSE_EN
        for (int b = 0; b < LOG2N; b++) r[b] = i[LOG2N-1-b];
`else
        r = i;
`endif
        return r;
    endfunction

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        emit    = 1'b0;
        last_wr = 1'b0;
        last_rd = 1'b0;
        case (state)
            FILL: begin
                accept  = bus.in_push && !bus.in_stall_F;
                last_wr = accept && (wr_idx == LAST_IDX);
                if (last_wr) state_d = DRAIN;
            end
            DRAIN: begin
                emit    = !bus.out_stall;
                last_rd = emit && (rd_idx == LAST_IDX);
                if (last_rd) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    // Stage p0: capture accepted samples; buffer contents need no reset.
    always_ff @(posedge clk) begin
        if (accept) mem[waddr(wr_idx)] <= {bus.in_real, bus.in_imag};
    end

    // Stage p1: control, indices and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= FILL;
            wr_idx           <= '0;
            rd_idx           <= '0;
            bus.in_stall_F   <= 1'b0;
            bus.out_push_F   <= 1'b0;
            bus.out_real_F   <= '0;
            bus.out_imag_F   <= '0;
            bus.frame_done_F <= 1'b0;
            bus.ovf_F        <= 1'b0;
            bus.frame_cnt_F  <= '0;
        end else begin
            state            <= state_d;
            bus.out_push_F   <= emit;
            bus.frame_done_F <= last_rd;

            // A push against a raised stall is dropped and remembered until reset.
            if (bus.in_push && bus.in_stall_F) bus.ovf_F <= 1'b1;

            if (accept) wr_idx <= last_wr ? '0 : wr_idx + 1'b1;

            if (last_wr)      bus.in_stall_F <= 1'b1;
            else if (last_rd) bus.in_stall_F <= 1'b0;

            if (emit) begin
                {bus.out_real_F, bus.out_imag_F} <= mem[rd_idx];
                rd_idx <= last_rd ? '0 : rd_idx + 1'b1;
            end

            if (last_rd) bus.frame_cnt_F <= bus.frame_cnt_F + 8'd1;
        end
    end

endmodule

// File: tb/tb_fft_frame_rx.sv
// Randomised scoreboard bench for fft_frame_rx against a frame-level reference model.
module tb_fft_frame_rx;
    localparam int N  = 16;
    localparam int LG = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fft_frame_rx_if #(.DW(DW)) bus();

    fft_frame_rx #(.N_POINTS(N), .LOG2N(LG), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: frame-level view of fill/drain behaviour
    bit          m_drain;
    int          m_wcnt, m_rcnt;
    logic [31:0] m_frame [N];
    logic [31:0] m_outf  [N];
    bit          m_ovf, m_push, m_done;
    bit   [7:0]  m_cnt;
    logic [31:0] m_last;
    logic [31:0] exp_q [$];
    int          frames_total = 0;
    int          done_seen    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int perm(input int j);
`ifdef BIT_REVERSE_EN
        int r = 0;
        int x = j;
        for (int b = 0; b < LG; b++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
`else
        return j;
`endif
    endfunction

    task automatic model_reset();
        m_drain = 0; m_wcnt = 0; m_rcnt = 0;
        m_ovf = 0; m_push = 0; m_done = 0; m_cnt = 0; m_last = '0;
        exp_q.delete();
    endtask

    task automatic model_update(input bit p, input logic [15:0] r, input logic [15:0] im, input bit s);
        m_push = 0;
        m_done = 0;
        if (!m_drain) begin
            if (p) begin
                m_frame[m_wcnt] = {r, im};
                m_wcnt++;
                if (m_wcnt == N) begin
                    for (int j = 0; j < N; j++) begin
                        m_outf[j] = m_frame[perm(j)];
                        exp_q.push_back(m_outf[j]);
                    end
                    m_wcnt  = 0;
                    m_drain = 1;
                end
            end
        end else begin
            if (p) m_ovf = 1;
            if (!s) begin
                m_push = 1;
                m_last = m_outf[m_rcnt];
                m_rcnt++;
                if (m_rcnt == N) begin
                    m_rcnt  = 0;
                    m_drain = 0;
                    m_done  = 1;
                    m_cnt++;
                    frames_total++;
                end
            end
        end
    endtask

    task automatic step(input bit p, input logic [15:0] r, input logic [15:0] im, input bit s);
        bus.in_push   = p;
        bus.in_real   = r;
        bus.in_imag   = im;
        bus.out_stall = s;
        @(posedge clk);
        model_update(p, r, im, s);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    // Monitor: compares every cycle on the falling edge, pops the scoreboard on each output push
    always @(negedge clk) begin
        chk("in_stall_F", 64'(bus.in_stall_F), 64'(m_drain));
        chk("ovf_F", 64'(bus.ovf_F), 64'(m_ovf));
        chk("frame_cnt_F", 64'(bus.frame_cnt_F), 64'(m_cnt));
        chk("frame_done_F", 64'(bus.frame_done_F), 64'(m_done));
        chk("out_push_F", 64'(bus.out_push_F), 64'(m_push));
        if (bus.out_push_F) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: got unexpected sample %0h expected none", {bus.out_real_F, bus.out_imag_F});
            end else begin
                chk("sample", 64'({bus.out_real_F, bus.out_imag_F}), 64'(exp_q.pop_front()));
            end
        end else begin
            chk("data_hold", 64'({bus.out_real_F, bus.out_imag_F}), 64'(m_last));
        end
        if (bus.frame_done_F) done_seen++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, cyc;
        bus.in_push = 0; bus.in_real = '0; bus.in_imag = '0; bus.out_stall = 0;
        reset = 1'b1;
        model_reset();
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Ramp frame: real=i, imag=-i, no back-pressure
        for (int i = 0; i < N; i++) step(1'b1, 16'(i), 16'(-i), 1'b0);
        idle(20);

        // Downstream stall for 5 cycles right after the frame fills
        for (int i = 0; i < N; i++) step(1'b1, 16'($urandom), 16'($urandom), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 16'h0, 1'b1);
        idle(20);

        // Continuous push for 20 cycles: the last 4 are dropped and flag overflow
        for (int i = 0; i < 20; i++) step(1'b1, 16'(100 + i), 16'(200 + i), 1'b0);
        idle(20);

        // Reset after 7 accepts, checked immediately, then a clean frame
        for (int i = 0; i < 7; i++) step(1'b1, 16'(50 + i), 16'(60 + i), 1'b0);
        #3 reset = 1'b0;
        model_reset();
        #1;
        chk("rst_out_push", 64'(bus.out_push_F), 64'd0);
        chk("rst_in_stall", 64'(bus.in_stall_F), 64'd0);
        chk("rst_ovf", 64'(bus.ovf_F), 64'd0);
        chk("rst_frame_cnt", 64'(bus.frame_cnt_F), 64'd0);
        chk("rst_frame_done", 64'(bus.frame_done_F), 64'd0);
        chk("rst_data", 64'({bus.out_real_F, bus.out_imag_F}), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < N; i++) step(1'b1, 16'($urandom), 16'($urandom), 1'b0);
        idle(20);

        // Random traffic for 256+ frames so frame_cnt_F wraps
        start = frames_total;
        cyc   = 0;
        while ((frames_total - start) < 256 && cyc < 40000) begin
            step($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom), $urandom_range(0, 3) == 0);
            cyc++;
        end
        chk("random_frames_done", 64'((frames_total - start) >= 256), 64'd1);
        idle(40);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("done_pulse_count", 64'(done_seen), 64'(frames_total));
        chk("frame_cnt_wrap", 64'(bus.frame_cnt_F), 64'(m_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
